// File: rtl/conv_sched_pkg.sv
// Shared types and parameter-derived sizing helpers for the convolution window scheduler.
package conv_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int out_dim(input int img, input int k);
      return img - k + 1;
   endfunction

   // A one-entry space still needs a 1-bit address.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/conv_window_addr_gen.sv
// Nested kc/kr/col/row walk over every output window and its kernel taps,
// with the weight and feature-map addresses derived from the current position.
module conv_window_addr_gen
   import conv_sched_pkg::*;
#(
   parameter int   KERNEL_SIZE = 5,
   parameter int   IMG_W       = 28,
   parameter int   IMG_H       = 28,
   localparam int  OUT_W       = out_dim(IMG_W, KERNEL_SIZE),
   localparam int  OUT_H       = out_dim(IMG_H, KERNEL_SIZE),
   localparam int  DA_W        = addr_w(IMG_W * IMG_H),
   localparam int  WA_W        = addr_w(KERNEL_SIZE * KERNEL_SIZE)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_clear,
   input  logic            i_advance,
   output logic [WA_W-1:0] o_weight_addr,
   output logic [DA_W-1:0] o_data_addr,
   output logic            o_last_tap
);

   localparam int KC_W  = addr_w(KERNEL_SIZE);
   localparam int COL_W = addr_w(OUT_W);
   localparam int ROW_W = addr_w(OUT_H);

   logic [KC_W-1:0]  r_kc;
   logic [KC_W-1:0]  r_kr;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             w_kc_last;
   logic             w_kr_last;
   logic             w_col_last;
   logic             w_row_last;

   assign w_kc_last  = (r_kc  == KC_W'(KERNEL_SIZE - 1));
   assign w_kr_last  = (r_kr  == KC_W'(KERNEL_SIZE - 1));
   assign w_col_last = (r_col == COL_W'(OUT_W - 1));
   assign w_row_last = (r_row == ROW_W'(OUT_H - 1));

   // Nested counters: kc fastest, row slowest; all wrap to 0 after the final tap.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_kc  <= '0;
         r_kr  <= '0;
         r_col <= '0;
         r_row <= '0;
      end else if (i_advance) begin
         if (w_kc_last) begin
            r_kc <= '0;
            if (w_kr_last) begin
               r_kr <= '0;
               if (w_col_last) begin
                  r_col <= '0;
                  if (w_row_last) begin
                     r_row <= '0;
                  end else begin
                     r_row <= r_row + 1'b1;
                  end
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end else begin
               r_kr <= r_kr + 1'b1;
            end
         end else begin
            r_kc <= r_kc + 1'b1;
         end
      end
   end

   assign o_weight_addr = WA_W'(32'(r_kr) * 32'(KERNEL_SIZE) + 32'(r_kc));
   assign o_data_addr   = DA_W'((32'(r_row) + 32'(r_kr)) * 32'(IMG_W) + 32'(r_col) + 32'(r_kc));
   assign o_last_tap    = w_kc_last & w_kr_last & w_col_last & w_row_last;

endmodule

// File: rtl/conv_window_sched.sv
// Layer-pass controller: issues every window's weight/data reads, aligns MAC
// valids with the one-cycle memory latency and writes each MAC result out.
module conv_window_sched
   import conv_sched_pkg::*;
#(
   parameter int   WIDTH       = 8,
   parameter int   KERNEL_SIZE = 5,
   parameter int   IMG_W       = 28,
   parameter int   IMG_H       = 28,
   localparam int  OUT_W       = out_dim(IMG_W, KERNEL_SIZE),
   localparam int  OUT_H       = out_dim(IMG_H, KERNEL_SIZE),
   localparam int  DA_W        = addr_w(IMG_W * IMG_H),
   localparam int  WA_W        = addr_w(KERNEL_SIZE * KERNEL_SIZE),
   localparam int  OA_W        = addr_w(OUT_W * OUT_H)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_stall,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_rd_en,
   output logic [WA_W-1:0]  o_weight_addr,
   output logic [DA_W-1:0]  o_data_addr,
   output logic             o_mu_weight_valid,
   output logic             o_mu_data_valid,
   output logic             o_mu_rst_n,
   input  logic             i_mu_result_valid,
   input  logic [WIDTH-1:0] i_mu_result,
   output logic             o_out_we,
   output logic [OA_W-1:0]  o_out_addr,
   output logic [WIDTH-1:0] o_out_data
);

   localparam logic [OA_W-1:0] LAST_OUT = OA_W'(OUT_W * OUT_H - 1);

   state_t          r_state;
   logic            r_busy;
   logic            r_done;
   logic            r_mu_valid;
   logic [OA_W-1:0] r_out_addr;
   logic            w_issue;
   logic            w_clear;
   logic            w_last_tap;
   logic            w_last_result;

   assign w_issue       = (r_state == ISSUE) && !i_stall;
   assign w_clear       = (r_state == IDLE) && i_start;
   assign w_last_result = i_mu_result_valid && (r_out_addr == LAST_OUT);

   conv_window_addr_gen #(
      .KERNEL_SIZE (KERNEL_SIZE),
      .IMG_W       (IMG_W),
      .IMG_H       (IMG_H)
   ) u_addr_gen (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_clear       (w_clear),
      .i_advance     (w_issue),
      .o_weight_addr (o_weight_addr),
      .o_data_addr   (o_data_addr),
      .o_last_tap    (w_last_tap)
   );

   // Pass sequencing; busy/done are registered alongside the state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_state <= ISSUE;
                  r_busy  <= 1'b1;
               end
            end
            ISSUE: begin
               if (w_issue && w_last_tap) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_last_result) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Read data lands one cycle after the strobe, so the MAC valid trails rd_en.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mu_valid <= 1'b0;
      end else begin
         r_mu_valid <= w_issue;
      end
   end

   // Result index follows the writes themselves, not the issue position.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_clear) begin
         r_out_addr <= '0;
      end else if (i_mu_result_valid) begin
         r_out_addr <= w_last_result ? '0 : r_out_addr + 1'b1;
      end
   end

   assign o_busy            = r_busy;
   assign o_done            = r_done;
   assign o_rd_en           = w_issue;
   assign o_mu_weight_valid = r_mu_valid;
   assign o_mu_data_valid   = r_mu_valid;
   assign o_mu_rst_n        = ~i_rst;
   assign o_out_we          = i_mu_result_valid;
   assign o_out_addr        = r_out_addr;
   assign o_out_data        = i_mu_result;

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench: K=2 on a 3x3 map with a memory+MAC model, plus one full-size pass.
module tb_conv_window_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // ---------------- small instance: K=2, 3x3 ----------------
   logic       rst, start, stall;
   logic       busy, done, rd_en, wv, dv, mrst_n, we;
   logic [1:0] wa, oa;
   logic [3:0] da;
   logic       mrv;
   logic [7:0] mres, od;

   conv_window_sched #(.WIDTH(8), .KERNEL_SIZE(2), .IMG_W(3), .IMG_H(3)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stall(stall),
      .o_busy(busy), .o_done(done), .o_rd_en(rd_en),
      .o_weight_addr(wa), .o_data_addr(da),
      .o_mu_weight_valid(wv), .o_mu_data_valid(dv), .o_mu_rst_n(mrst_n),
      .i_mu_result_valid(mrv), .i_mu_result(mres),
      .o_out_we(we), .o_out_addr(oa), .o_out_data(od)
   );

   // memory model: data[a] = a+1, weight[w] = w+1, one-cycle read latency
   logic [7:0] m_d, m_w, m_acc;
   logic [1:0] m_cnt;
   always @(posedge clk) begin
      if (rd_en) begin
         m_d <= 8'(da) + 8'd1;
         m_w <= 8'(wa) + 8'd1;
      end
   end

   always @(posedge clk) begin
      if (!mrst_n) begin
         m_acc <= 8'd0;
         m_cnt <= 2'd0;
         mrv   <= 1'b0;
      end else begin
         mrv <= 1'b0;
         if (dv) begin
            if (m_cnt == 2'd3) begin
               mres  <= m_acc + m_d * m_w;
               mrv   <= 1'b1;
               m_acc <= 8'd0;
               m_cnt <= 2'd0;
            end else begin
               m_acc <= m_acc + m_d * m_w;
               m_cnt <= m_cnt + 2'd1;
            end
         end
      end
   end

   // ---------------- full-size instance: defaults ----------------
   logic       b_rst, b_start, b_stall;
   logic       b_busy, b_done, b_rd_en, b_wv, b_dv, b_mrst_n, b_we, b_mrv;
   logic [4:0] b_wa, b_cnt;
   logic [9:0] b_da, b_oa;
   logic [7:0] b_mres, b_od;
   assign b_mres = 8'd0;

   conv_window_sched b_dut (
      .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_stall(b_stall),
      .o_busy(b_busy), .o_done(b_done), .o_rd_en(b_rd_en),
      .o_weight_addr(b_wa), .o_data_addr(b_da),
      .o_mu_weight_valid(b_wv), .o_mu_data_valid(b_dv), .o_mu_rst_n(b_mrst_n),
      .i_mu_result_valid(b_mrv), .i_mu_result(b_mres),
      .o_out_we(b_we), .o_out_addr(b_oa), .o_out_data(b_od)
   );

   always @(posedge clk) begin
      if (!b_mrst_n) begin
         b_cnt <= 5'd0;
         b_mrv <= 1'b0;
      end else begin
         b_mrv <= 1'b0;
         if (b_dv) begin
            if (b_cnt == 5'd24) begin
               b_cnt <= 5'd0;
               b_mrv <= 1'b1;
            end else begin
               b_cnt <= b_cnt + 5'd1;
            end
         end
      end
   end

   // ---------------- logs and helpers ----------------
   int rd_cyc[$], rd_da[$], rd_wa[$], we_cyc[$], we_addr[$], we_data[$], done_cyc[$];
   int b_we_cnt = 0, b_rd_cnt = 0, b_last_oa = -1, b_done_cyc = -1, b_vpair_bad = 0;

   int exp_da  [16] = '{0, 1, 3, 4, 1, 2, 4, 5, 3, 4, 6, 7, 4, 5, 7, 8};
   int exp_res [4]  = '{37, 47, 67, 77};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      rd_cyc.delete(); rd_da.delete(); rd_wa.delete();
      we_cyc.delete(); we_addr.delete(); we_data.delete(); done_cyc.delete();
   endtask

   // Drive cycle inputs just after the edge, log outputs at the falling edge.
   task automatic step(input logic st, input logic sl, input logic rs, input logic bst);
      @(posedge clk);
      #1;
      cyc     = cyc + 1;
      start   = st;
      stall   = sl;
      rst     = rs;
      b_start = bst;
      @(negedge clk);
      if (rd_en) begin
         rd_cyc.push_back(cyc); rd_da.push_back(int'(da)); rd_wa.push_back(int'(wa));
      end
      if (we) begin
         we_cyc.push_back(cyc); we_addr.push_back(int'(oa)); we_data.push_back(int'(od));
      end
      if (done) done_cyc.push_back(cyc);
      if (b_rd_en) b_rd_cnt++;
      if (b_we) begin
         b_we_cnt++;
         b_last_oa = int'(b_oa);
      end
      if (b_done) b_done_cyc = cyc;
      if (b_wv !== b_dv) b_vpair_bad++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0;
      b_rst = 1'b1; b_start = 1'b0; b_stall = 1'b0;

      // reset state
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_done", done, 32'd0);
      chk("rst_rd_en", rd_en, 32'd0);
      chk("rst_waddr", wa, 32'd0);
      chk("rst_daddr", da, 32'd0);
      chk("rst_valid", dv, 32'd0);
      chk("rst_oaddr", oa, 32'd0);
      chk("rst_out_we", we, 32'd0);
      chk("rst_mu_rst_n", mrst_n, 32'd0);

      // pass A: basic, extra starts in cycles 5 and 19, restart in cycle 20
      clear_logs();
      cyc = -1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 20; c++) begin
         step(c == 5 || c == 19 || c == 20, 1'b0, 1'b0, 1'b0);
         chk("pA_vpair", wv, dv);
         if (c == 1) chk("pA_busy", busy, 32'd1);
         if (c == 17) chk("pA_drain_rd_en", rd_en, 32'd0);
      end
      chk("pA_idle_busy", busy, 32'd0);
      chk("pA_mu_rst_n", mrst_n, 32'd1);
      chk("pA_rd_count", rd_cyc.size(), 32'd16);
      for (int i = 0; i < 16; i++) begin
         if (i < rd_cyc.size()) begin
            chk($sformatf("pA_rd_cyc%0d", i), rd_cyc[i], i + 1);
            chk($sformatf("pA_daddr%0d", i), rd_da[i], exp_da[i]);
            chk($sformatf("pA_waddr%0d", i), rd_wa[i], i % 4);
         end
      end
      chk("pA_we_count", we_cyc.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < we_cyc.size()) begin
            chk($sformatf("pA_we_cyc%0d", i), we_cyc[i], 6 + 4 * i);
            chk($sformatf("pA_oaddr%0d", i), we_addr[i], i);
            chk($sformatf("pA_odata%0d", i), we_data[i], exp_res[i]);
         end
      end
      chk("pA_done_count", done_cyc.size(), 32'd1);
      if (done_cyc.size() > 0) chk("pA_done_cyc", done_cyc[0], 32'd19);

      // pass B: started in cycle 20 of pass A, stall in cycles 3-4
      clear_logs();
      cyc = 0;
      for (int c = 1; c <= 24; c++) begin
         step(1'b0, c == 3 || c == 4, 1'b0, 1'b0);
         if (c == 1) chk("pB_first_rd_en", rd_en, 32'd1);
         if (c == 3 || c == 4) begin
            chk($sformatf("pB_stall_rd_en%0d", c), rd_en, 32'd0);
            chk($sformatf("pB_stall_daddr%0d", c), da, 32'd3);
         end
      end
      chk("pB_rd_count", rd_cyc.size(), 32'd16);
      if (rd_cyc.size() == 16) begin
         chk("pB_resume_cyc", rd_cyc[2], 32'd5);
         chk("pB_resume_daddr", rd_da[2], 32'd3);
         chk("pB_last_rd_cyc", rd_cyc[15], 32'd18);
      end
      chk("pB_we_count", we_cyc.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < we_cyc.size()) chk($sformatf("pB_odata%0d", i), we_data[i], exp_res[i]);
      end
      if (we_cyc.size() == 4) chk("pB_last_we_cyc", we_cyc[3], 32'd20);
      chk("pB_done_count", done_cyc.size(), 32'd1);
      if (done_cyc.size() > 0) chk("pB_done_cyc", done_cyc[0], 32'd21);

      // pass C: reset in cycle 7, then a clean pass
      clear_logs();
      cyc = -1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 6; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("pC_mu_rst_n_in_rst", mrst_n, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("pC_busy", busy, 32'd0);
      chk("pC_out_we", we, 32'd0);
      chk("pC_rd_en", rd_en, 32'd0);
      chk("pC_oaddr", oa, 32'd0);
      chk("pC_daddr", da, 32'd0);
      chk("pC_valid", dv, 32'd0);
      chk("pC_pre_we_count", we_cyc.size(), 32'd1);
      clear_logs();
      cyc = -1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 20; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("pC_we_count", we_cyc.size(), 32'd4);
      if (we_cyc.size() > 0) begin
         chk("pC_first_data", we_data[0], 32'd37);
         chk("pC_first_addr", we_addr[0], 32'd0);
         chk("pC_first_cyc", we_cyc[0], 32'd6);
      end
      chk("pC_done_count", done_cyc.size(), 32'd1);
      if (done_cyc.size() > 0) chk("pC_done_cyc", done_cyc[0], 32'd19);

      // full-size pass with default parameters
      b_rst = 1'b0;
      cyc = -1;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int c = 1; c <= 14406; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("big_rd_count", b_rd_cnt, 32'd14400);
      chk("big_we_count", b_we_cnt, 32'd576);
      chk("big_last_oaddr", b_last_oa, 32'd575);
      chk("big_done_cyc", b_done_cyc, 32'd14403);
      chk("big_idle_busy", b_busy, 32'd0);
      chk("big_vpair", b_vpair_bad, 32'd0);
      chk("big_end_daddr", b_da, 32'd0);
      chk("big_end_waddr", b_wa, 32'd0);
      chk("big_odata", b_od, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_window_sched.md
# conv_window_sched

Controller that sequences the kernel multiply-accumulate unit over a full feature map for one valid (no-padding) convolution. On `start` it walks every output position in row-major order and, for each, issues KERNEL_SIZE² weight/data read pairs in kernel row-major order. It aligns the MAC valids with the 1-cycle memory read latency and writes each finished MAC result to the output buffer. It sits between the weight/feature-map memories, the MAC unit and the output buffer, under the layer-level control FSM.

## Interface
- WIDTH, 8, data/weight/result width
- KERNEL_SIZE, 5, kernel edge length K
- IMG_W, 28, input feature-map width (≥ K)
- IMG_H, 28, input feature-map height (≥ K)
- Derived: OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1; DA_W = $clog2(IMG_W*IMG_H), WA_W = $clog2(K*K), OA_W = $clog2(OUT_W*OUT_H) (min 1 each)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- stall  in  1  suppress issue this cycle (upstream memory not ready)
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse after the last result write
- rd_en  out  1  read strobe to the weight and data memories
- weight_addr  out  WA_W  kernel tap index kr*K+kc
- data_addr  out  DA_W  (row+kr)*IMG_W + (col+kc)
- mu_weight_valid, mu_data_valid  out  1  rd_en delayed one cycle; both always equal
- mu_rst_n  out  1  = !rst, keeps the MAC tap counter aligned with this block
- mu_result_valid  in  1  MAC conv_result_valid
- mu_result  in  WIDTH  MAC conv_result
- out_we  out  1  = mu_result_valid
- out_addr  out  OA_W  output index row*OUT_W+col of the result being written
- out_data  out  WIDTH  = mu_result

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: if start=1, clear all counters and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: rd_en = !stall. Each issued cycle advances kc, then kr, then col, then row (nested wrap).
  - kc wraps at K-1. kr wraps at K-1. col wraps at OUT_W-1. row is last at OUT_H-1.
  - After issuing the final tap of the final window, go to DRAIN.
- DRAIN: wait for the final out_we, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Stall behaviour: stall=1 holds every counter and drives rd_en=0. Already-issued reads still produce their MAC valid one cycle later. Stall has no effect outside ISSUE.
- Result indexing: out_addr comes from a separate result counter. It starts at 0 and increments on each out_we, so it is independent of the issue counters.
- start while busy: ignored. start in DONE: ignored. A new pass needs IDLE.
- Reset mid-pass:
  - Next cycle the block is in IDLE with all counters 0.
  - In-flight valids are squashed.
  - mu_rst_n=0 forces the MAC accumulator and tap counter to 0, so no partial window survives.
- Bias is not handled here; the MAC's bias input is wired externally.

## Timing
- Reset values: busy=0, done=0, rd_en=0, weight_addr=0, data_addr=0, mu_*_valid=0, out_addr=0. out_we and out_data follow the MAC, which is also held in reset.
- Edge 0 samples start. The first rd_en is in cycle 1, with addresses valid in the same cycle as rd_en.
- Memory data returns and mu_*_valid are high in cycle t+1 for an issue in cycle t.
- With no stall, the last issue is in cycle N = OUT_W*OUT_H*K². The final MAC valid is in N+1, the final out_we in N+2, done in N+3, and IDLE from N+4.
- Each stalled cycle adds exactly 1 to all of these.
- Windows issue back-to-back with no bubble between windows.

## Structure
- Package conv_sched_pkg holds:
  - the state enum type (IDLE, ISSUE, DRAIN, DONE);
  - functions computing OUT_W, OUT_H and the address widths from the parameters.
- Sub-module conv_window_addr_gen holds:
  - the kc/kr/col/row nested counters with an advance input;
  - the combinational weight_addr/data_addr generation;
  - a last_tap output.
- The top level holds the FSM, the rd_en→valid delay register and the result counter.

## Test plan
All scenarios use K=2, IMG 3x3 (OUT 2x2, N=16).
- Basic pass, MAC model attached, no stall:
  - data_addr across cycles 1-16 must be 0,1,3,4 | 1,2,4,5 | 3,4,6,7 | 4,5,7,8.
  - weight_addr must repeat 0,1,2,3.
  - out_we must fire in cycles 6, 10, 14 and 18 with out_addr 0,1,2,3.
  - done must pulse in cycle 19.
- Stall high in cycles 3-4: rd_en=0 and addresses held at data_addr 3 in those cycles; out_we fires last in cycle 20; done in cycle 21.
- start pulsed again in cycles 5 and 19: no effect, counters undisturbed. A start in cycle 20 (IDLE) begins a new pass with rd_en in cycle 21.
- rst high in cycle 7:
  - Cycle 8: state IDLE, busy=0, no out_we, mu_rst_n was 0 during the reset cycle.
  - A new start gives a first result equal to window (0,0).
- Full-size default parameters: 576 out_we pulses, out_addr ending at 575, done at cycle 14403.
